// File: rtl/rd_pkg.sv
// -----------------------------------------------------------------------------
// rd_pkg
// Shared constants, FSM state type and lane-mask helper for the RD feature-map
// write-back path.
//   CH_NUM       output channels packed in one activation SRAM word
//   ACT_PER_ADDR activation slots per channel per word
//   BW_PER_ACT   bits per activation
//   ADDR_BW      SRAM word address width
//   PE_LAT       request-to-result latency of the PE array
// -----------------------------------------------------------------------------
package rd_pkg;

   localparam int CH_NUM       = 24;
   localparam int ACT_PER_ADDR = 4;
   localparam int BW_PER_ACT   = 16;
   localparam int ADDR_BW      = 10;
   localparam int PE_LAT       = 5;
   localparam int IDX_BW       = 7;
   localparam int LANES        = CH_NUM * ACT_PER_ADDR;
   localparam int WDATA_BW     = LANES * BW_PER_ACT;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } rd_state_e;

   // Active-low lane mask for one channel. Channel k owns the lane group
   // counted from the top of the word, so its enabled lane is
   // (CH_NUM-1-k)*ACT_PER_ADDR (lane 92 for k=0, lane 0 for k=23).
   // Indices outside 0..CH_NUM-1 enable nothing.
   function automatic logic [LANES-1:0] rd_lane_mask(input logic [IDX_BW-1:0] idx);
      logic [LANES-1:0] m;
      m = '1;
      for (int k = 0; k < CH_NUM; k++) begin
         if (idx == IDX_BW'(k)) begin
            m[(CH_NUM-1-k)*ACT_PER_ADDR] = 1'b0;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/write_RD_case.sv
// -----------------------------------------------------------------------------
// write_RD_case
// Per-channel byte-mask decoder for the activation SRAM write port.
// Purely combinational so the mask lines up with the registered write outputs
// that produced fmap_idx_wr.
//   fmap_idx_wr    in   channel index of the write being presented
//   sram_bytemask  out  active-low lane mask (one lane cleared per channel)
// -----------------------------------------------------------------------------
module write_RD_case
   import rd_pkg::*;
(
   input  logic [IDX_BW-1:0] fmap_idx_wr,
   output logic [LANES-1:0]  sram_bytemask
);

   always_comb begin
      sram_bytemask = rd_lane_mask(fmap_idx_wr);
   end

endmodule

// File: rtl/rd_write_ctrl.sv
// -----------------------------------------------------------------------------
// rd_write_ctrl
// Write-back sequencer for the RD feature-map stage. Walks channel index
// (inner) over SRAM word address (outer), issues one PE request per accepted
// cycle, delays the request tags PE_LAT cycles to meet the PE result, applies
// optional ReLU and drives the activation SRAM write port.
//   clk, rst_n         clock, synchronous active-low reset
//   start              one-cycle pass start, honoured only in IDLE
//   num_addr, relu_en  pass configuration, captured on start
//   issue_rdy          PE array accepts a request this cycle
//   req_valid/req_*    request to the PE array (channel index, word address)
//   pe_result_valid/pe_result  PE result, PE_LAT cycles after the request
//   sram_wen/waddr/wdata/bytemask  activation SRAM write port (active-low)
//   busy, done, err    status: pass active, end-of-pass pulse, sticky error
//   state_dbg          current FSM state for observation
// -----------------------------------------------------------------------------
module rd_write_ctrl
   import rd_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_BW-1:0]    num_addr,
   input  logic                  relu_en,
   input  logic                  issue_rdy,
   output logic                  req_valid,
   output logic [IDX_BW-1:0]     req_fmap_idx,
   output logic [ADDR_BW-1:0]    req_addr,
   input  logic                  pe_result_valid,
   input  logic [BW_PER_ACT-1:0] pe_result,
   output logic                  sram_wen,
   output logic [ADDR_BW-1:0]    sram_waddr,
   output logic [WDATA_BW-1:0]   sram_wdata,
   output logic [LANES-1:0]      sram_bytemask,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output rd_state_e             state_dbg
);

   rd_state_e state_q, state_d;

   logic [IDX_BW-1:0]  idx_q;
   logic [ADDR_BW-1:0] addr_q;
   logic [ADDR_BW-1:0] num_addr_q;
   logic               relu_q;

   // Delay line: element 0 is stage 1, element PE_LAT-1 is stage 5.
   logic [PE_LAT-1:0]  dl_v_q;
   logic [IDX_BW-1:0]  dl_idx_q  [PE_LAT];
   logic [ADDR_BW-1:0] dl_addr_q [PE_LAT];

   logic [IDX_BW-1:0]     fmap_idx_wr;
   logic [BW_PER_ACT-1:0] act;
   logic                  last_issue;
   logic                  tail_busy;
   logic                  done_q;
   logic                  err_q;

   // Request handshake: a request transfers in every cycle where req_valid and
   // issue_rdy are both high. req_valid is only raised while issue_rdy is high,
   // so req_valid alone marks a transfer; the counters advance only on it.
   assign req_valid    = (state_q == RUN) && issue_rdy;
   assign req_fmap_idx = idx_q;
   assign req_addr     = addr_q;

   assign last_issue = req_valid
                    && (idx_q == IDX_BW'(CH_NUM - 1))
                    && (addr_q == num_addr_q - ADDR_BW'(1));

   // Stage 5 is moved into the output register on every edge, so once stages
   // 1..4 hold no valid the final write is already on its way out. Leaving
   // DRAIN here makes the registered done pulse land on the first cycle after
   // that final write.
   assign tail_busy = |dl_v_q[PE_LAT-2:0];

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign state_dbg = state_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (num_addr == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (last_issue) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!tail_busy) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == DONE);
      end
   end

   // Channel/address counters and captured pass configuration.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q      <= '0;
         addr_q     <= '0;
         num_addr_q <= '0;
         relu_q     <= 1'b0;
      end else if ((state_q == IDLE) && start) begin
         idx_q      <= '0;
         addr_q     <= '0;
         num_addr_q <= num_addr;
         relu_q     <= relu_en;
      end else if (req_valid) begin
         if (idx_q == IDX_BW'(CH_NUM - 1)) begin
            idx_q  <= '0;
            addr_q <= addr_q + ADDR_BW'(1);
         end else begin
            idx_q  <= idx_q + IDX_BW'(1);
         end
      end
   end

   // Tag delay line: shifts every cycle, bubbles included, never stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dl_v_q <= '0;
         for (int s = 0; s < PE_LAT; s++) begin
            dl_idx_q[s]  <= '0;
            dl_addr_q[s] <= '0;
         end
      end else begin
         dl_v_q       <= {dl_v_q[PE_LAT-2:0], req_valid};
         dl_idx_q[0]  <= idx_q;
         dl_addr_q[0] <= addr_q;
         for (int s = 1; s < PE_LAT; s++) begin
            dl_idx_q[s]  <= dl_idx_q[s-1];
            dl_addr_q[s] <= dl_addr_q[s-1];
         end
      end
   end

   assign act = (relu_q && pe_result[BW_PER_ACT-1]) ? '0 : pe_result;

   // Output register plus sticky result/tag alignment check.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sram_wen    <= 1'b1;
         sram_waddr  <= '0;
         sram_wdata  <= '0;
         fmap_idx_wr <= '0;
         err_q       <= 1'b0;
      end else begin
         sram_wen    <= ~dl_v_q[PE_LAT-1];
         sram_waddr  <= dl_addr_q[PE_LAT-1];
         sram_wdata  <= {LANES{act}};
         fmap_idx_wr <= dl_idx_q[PE_LAT-1];
         err_q       <= err_q | (dl_v_q[PE_LAT-1] != pe_result_valid);
      end
   end

   write_RD_case u_write_rd_case (
      .fmap_idx_wr   (fmap_idx_wr),
      .sram_bytemask (sram_bytemask)
   );

endmodule
